// File: rtl/player_motion_ctl.sv
// player_motion_ctl
//   Advances the sprite position of NUM_PLAYERS independent players once per
//   video frame (rising edge of v_tick) in the clk_40 domain. Each channel
//   saturates horizontal motion at X_MIN/X_MAX and runs a GROUND/RISE/FALL
//   jump state machine.
//
// Ports
//   clk_40       pixel clock, the only clock
//   rst          asynchronous active-high reset
//   v_tick       vsync level; its rising edge is the frame tick
//   enable       high while playing; low freezes all motion
//   restart      one-cycle request to return all players to reset positions
//   m_left       per-player move-left request  (bit i = player i)
//   m_right      per-player move-right request
//   jump         per-player jump request
//   xpos_player  packed x positions, player i at [i*PW +: PW]
//   ypos_player  packed y positions, same packing
//   airborne     per-player flag, high while not in GROUND
//   frame_done   one-cycle pulse marking a position update
module player_motion_ctl #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned PW          = 12,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 768,
    parameter int unsigned X_SPACING   = 200,
    parameter int unsigned Y_FLOOR     = 536,
    parameter int unsigned STEP        = 4,
    parameter int unsigned JUMP_STEP   = 4,
    parameter int unsigned JUMP_HEIGHT = 96
) (
    input  logic                      clk_40,
    input  logic                      rst,
    input  logic                      v_tick,
    input  logic                      enable,
    input  logic                      restart,
    input  logic [NUM_PLAYERS-1:0]    m_left,
    input  logic [NUM_PLAYERS-1:0]    m_right,
    input  logic [NUM_PLAYERS-1:0]    jump,
    output logic [NUM_PLAYERS*PW-1:0] xpos_player,
    output logic [NUM_PLAYERS*PW-1:0] ypos_player,
    output logic [NUM_PLAYERS-1:0]    airborne,
    output logic                      frame_done
);

    typedef enum logic [1:0] {
        GROUND,
        RISE,
        FALL
    } jump_state_t;

    // Comparisons are done one bit wider than PW so additions cannot wrap.
    localparam logic [PW:0]   X_MIN_W     = (PW+1)'(X_MIN);
    localparam logic [PW:0]   X_MAX_W     = (PW+1)'(X_MAX);
    localparam logic [PW:0]   STEP_W      = (PW+1)'(STEP);
    localparam logic [PW:0]   JSTEP_W     = (PW+1)'(JUMP_STEP);
    localparam logic [PW:0]   Y_FLOOR_W   = (PW+1)'(Y_FLOOR);
    localparam logic [PW:0]   Y_APEX_W    = (PW+1)'(Y_FLOOR - JUMP_HEIGHT);
    localparam logic [PW-1:0] X_MIN_P     = PW'(X_MIN);
    localparam logic [PW-1:0] X_MAX_P     = PW'(X_MAX);
    localparam logic [PW-1:0] STEP_P      = PW'(STEP);
    localparam logic [PW-1:0] JSTEP_P     = PW'(JUMP_STEP);
    localparam logic [PW-1:0] Y_FLOOR_P   = PW'(Y_FLOOR);
    localparam logic [PW-1:0] Y_APEX_P    = PW'(Y_FLOOR - JUMP_HEIGHT);

    logic [PW-1:0]          x_q  [NUM_PLAYERS];
    logic [PW-1:0]          x_d  [NUM_PLAYERS];
    logic [PW-1:0]          y_q  [NUM_PLAYERS];
    logic [PW-1:0]          y_d  [NUM_PLAYERS];
    jump_state_t            st_q [NUM_PLAYERS];
    jump_state_t            st_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] air_q;
    logic [NUM_PLAYERS-1:0] air_d;
    logic                   v_tick_q;
    logic                   frame_done_q;
    logic                   frame_done_d;
    logic                   tick;

    function automatic logic [PW-1:0] reset_x(input int unsigned idx);
        return PW'(X_MIN + idx * X_SPACING);
    endfunction

    assign tick = v_tick & ~v_tick_q;

    always_comb begin
        frame_done_d = tick & enable & ~restart;
        air_d        = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            st_d[i] = st_q[i];
            if (restart) begin
                x_d[i]  = reset_x(i);
                y_d[i]  = Y_FLOOR_P;
                st_d[i] = GROUND;
            end else if (tick && enable) begin
                if (m_left[i] && !m_right[i]) begin
                    x_d[i] = ({1'b0, x_q[i]} < X_MIN_W + STEP_W) ? X_MIN_P
                                                                 : x_q[i] - STEP_P;
                end else if (m_right[i] && !m_left[i]) begin
                    x_d[i] = ({1'b0, x_q[i]} + STEP_W >= X_MAX_W) ? X_MAX_P
                                                                  : x_q[i] + STEP_P;
                end
                unique case (st_q[i])
                    GROUND: begin
                        if (jump[i]) begin
                            y_d[i]  = y_q[i] - JSTEP_P;
                            st_d[i] = RISE;
                        end
                    end
                    RISE: begin
                        // y - JUMP_STEP <= apex, rearranged to avoid underflow
                        if ({1'b0, y_q[i]} <= Y_APEX_W + JSTEP_W) begin
                            y_d[i]  = Y_APEX_P;
                            st_d[i] = FALL;
                        end else begin
                            y_d[i]  = y_q[i] - JSTEP_P;
                        end
                    end
                    FALL: begin
                        if ({1'b0, y_q[i]} + JSTEP_W >= Y_FLOOR_W) begin
                            y_d[i]  = Y_FLOOR_P;
                            st_d[i] = GROUND;
                        end else begin
                            y_d[i]  = y_q[i] + JSTEP_P;
                        end
                    end
                    default: begin
                        y_d[i]  = Y_FLOOR_P;
                        st_d[i] = GROUND;
                    end
                endcase
            end
            air_d[i] = (st_d[i] != GROUND);
        end
    end

    always_ff @(posedge clk_40 or posedge rst) begin
        if (rst) begin
            // Held at 1 so a v_tick already high at reset release is not a tick
            v_tick_q     <= 1'b1;
            frame_done_q <= 1'b0;
            air_q        <= '0;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                x_q[i]  <= reset_x(i);
                y_q[i]  <= Y_FLOOR_P;
                st_q[i] <= GROUND;
            end
        end else begin
            v_tick_q     <= v_tick;
            frame_done_q <= frame_done_d;
            air_q        <= air_d;
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                st_q[i] <= st_d[i];
            end
        end
    end

    always_comb begin
        xpos_player = '0;
        ypos_player = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            xpos_player[i*PW +: PW] = x_q[i];
            ypos_player[i*PW +: PW] = y_q[i];
        end
    end

    assign airborne   = air_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_player_motion_ctl.sv
// tb_player_motion_ctl
//   Self-checking bench for player_motion_ctl with default parameters.
//   A behavioural model tracks each player as an x value plus a jump phase
//   counter (0 = on ground, 1..47 = ticks into a jump) and derives y from it.
module tb_player_motion_ctl;

    localparam int NP    = 2;
    localparam int PW    = 12;
    localparam int HALF  = 96 / 4;
    localparam int TOTAL = 2 * HALF;

    logic            clk_40 = 1'b0;
    logic            rst;
    logic            v_tick;
    logic            enable;
    logic            restart;
    logic [NP-1:0]   m_left;
    logic [NP-1:0]   m_right;
    logic [NP-1:0]   jump;
    logic [NP*PW-1:0] xpos_player;
    logic [NP*PW-1:0] ypos_player;
    logic [NP-1:0]   airborne;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    int mx[NP];
    int mc[NP];
    logic mfd;

    player_motion_ctl #(
        .NUM_PLAYERS(NP),
        .PW(PW)
    ) dut (
        .clk_40(clk_40),
        .rst(rst),
        .v_tick(v_tick),
        .enable(enable),
        .restart(restart),
        .m_left(m_left),
        .m_right(m_right),
        .jump(jump),
        .xpos_player(xpos_player),
        .ypos_player(ypos_player),
        .airborne(airborne),
        .frame_done(frame_done)
    );

    always #5 clk_40 = ~clk_40;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_y(input int c);
        return (c <= HALF) ? 536 - 4 * c : 536 - 4 * (TOTAL - c);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mx[p] = p * 200;
            mc[p] = 0;
        end
        mfd = 1'b0;
    endtask

    task automatic model_tick(input logic en, input logic rs,
                              input logic [NP-1:0] l, input logic [NP-1:0] r,
                              input logic [NP-1:0] j);
        if (rs) begin
            model_reset();
        end else if (en) begin
            for (int p = 0; p < NP; p++) begin
                if (l[p] && !r[p]) mx[p] = (mx[p] - 4 < 0) ? 0 : mx[p] - 4;
                if (r[p] && !l[p]) mx[p] = (mx[p] + 4 > 768) ? 768 : mx[p] + 4;
                if (mc[p] == 0) mc[p] = j[p] ? 1 : 0;
                else            mc[p] = (mc[p] + 1) % TOTAL;
            end
            mfd = 1'b1;
        end else begin
            mfd = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s x%0d", tag, p), 32'(xpos_player[p*PW +: PW]), 32'(mx[p]));
            chk($sformatf("%s y%0d", tag, p), 32'(ypos_player[p*PW +: PW]), 32'(model_y(mc[p])));
            chk($sformatf("%s air%0d", tag, p), 32'(airborne[p]), 32'(mc[p] != 0));
        end
        chk($sformatf("%s fd", tag), 32'(frame_done), 32'(mfd));
    endtask

    // One frame: tick edge with the given requests, then v_tick low for a cycle.
    task automatic do_tick(input logic en, input logic rs,
                           input logic [NP-1:0] l, input logic [NP-1:0] r,
                           input logic [NP-1:0] j);
        @(negedge clk_40);
        enable = en; restart = rs; m_left = l; m_right = r; jump = j;
        v_tick = 1'b1;
        @(posedge clk_40);
        #1;
        model_tick(en, rs, l, r, j);
        chk_model("tick");
        @(negedge clk_40);
        v_tick = 1'b0;
        restart = 1'b0;
        @(posedge clk_40);
        #1;
        chk("fd_low", 32'(frame_done), 32'(0));
    endtask

    typedef struct {
        logic          en;
        logic          rs;
        logic [NP-1:0] l;
        logic [NP-1:0] r;
        logic [NP-1:0] j;
        int            ex0;
        int            ex1;
        int            ey0;
        int            ey1;
        logic [NP-1:0] eair;
        logic          efd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 2'b00, 2'b01, 2'b00,   4, 200, 536, 536, 2'b00, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 2'b10, 2'b00, 2'b00,   4, 196, 536, 536, 2'b00, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 2'b11, 2'b11, 2'b00,   4, 196, 536, 536, 2'b00, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 2'b11, 2'b11, 2'b11,   4, 196, 536, 536, 2'b00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 2'b00, 2'b00, 2'b01,   4, 196, 532, 536, 2'b01, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 2'b00, 2'b11, 2'b00,   8, 200, 528, 536, 2'b01, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 2'b00, 2'b11, 2'b11,   0, 200, 536, 536, 2'b00, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'b00, 2'b10, 2'b10,   0, 204, 536, 532, 2'b10, 1'b1};

        rst = 1'b1; v_tick = 1'b1; enable = 1'b0; restart = 1'b0;
        m_left = '0; m_right = '0; jump = '0;
        model_reset();
        repeat (3) @(posedge clk_40);
        @(negedge clk_40);
        rst = 1'b0;
        enable = 1'b1;

        // v_tick high across reset release must not produce a tick
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_40);
            #1;
            chk("reset_no_fd", 32'(frame_done), 32'(0));
        end
        chk_model("reset");
        @(negedge clk_40);
        v_tick = 1'b0;
        @(posedge clk_40);
        #1;
        chk("reset_fd_low", 32'(frame_done), 32'(0));

        // Table vectors starting from the reset state
        for (int v = 0; v < 8; v++) begin
            do_tick(tbl[v].en, tbl[v].rs, tbl[v].l, tbl[v].r, tbl[v].j);
        end
        // Re-check the table's last vector after the hold cycle: outputs stable
        chk("tbl_last x0", 32'(xpos_player[0 +: PW]), 32'(tbl[7].ex0));
        for (int v = 0; v < 8; v++) begin
            // replay from reset so each row is checked against hand values
            if (v == 0) do_tick(1'b1, 1'b1, '0, '0, '0);
            do_tick(tbl[v].en, tbl[v].rs, tbl[v].l, tbl[v].r, tbl[v].j);
            chk($sformatf("tbl%0d x0", v), 32'(xpos_player[0 +: PW]), 32'(tbl[v].ex0));
            chk($sformatf("tbl%0d x1", v), 32'(xpos_player[PW +: PW]), 32'(tbl[v].ex1));
            chk($sformatf("tbl%0d y0", v), 32'(ypos_player[0 +: PW]), 32'(tbl[v].ey0));
            chk($sformatf("tbl%0d y1", v), 32'(ypos_player[PW +: PW]), 32'(tbl[v].ey1));
            chk($sformatf("tbl%0d air", v), 32'(airborne), 32'(tbl[v].eair));
        end

        // Horizontal saturation: p0 right, p1 left for 200 ticks
        do_tick(1'b1, 1'b1, '0, '0, '0);
        for (int k = 1; k <= 200; k++) begin
            do_tick(1'b1, 1'b0, 2'b10, 2'b01, 2'b00);
            if (k == 49)  chk("sat x1@49",  32'(xpos_player[PW +: PW]), 32'(4));
            if (k == 50)  chk("sat x1@50",  32'(xpos_player[PW +: PW]), 32'(0));
            if (k == 191) chk("sat x0@191", 32'(xpos_player[0 +: PW]), 32'(764));
            if (k == 192) chk("sat x0@192", 32'(xpos_player[0 +: PW]), 32'(768));
            if (k == 200) chk("sat x0@200", 32'(xpos_player[0 +: PW]), 32'(768));
        end

        // Both directions on p1 hold x1, frame_done pulses every tick
        do_tick(1'b1, 1'b1, '0, '0, '0);
        begin
            int pulses = 0;
            for (int k = 0; k < 10; k++) begin
                do_tick(1'b1, 1'b0, 2'b10, 2'b10, 2'b00);
                if (frame_done === 1'b0) pulses = pulses;
            end
            chk("both x1", 32'(xpos_player[PW +: PW]), 32'(200));
        end

        // Full jump with jump held the whole time, then re-jump after landing
        do_tick(1'b1, 1'b1, '0, '0, '0);
        for (int k = 1; k <= 48; k++) begin
            do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b01);
            if (k == 1)  chk("jump y0@1",  32'(ypos_player[0 +: PW]), 32'(532));
            if (k == 24) chk("jump y0@24", 32'(ypos_player[0 +: PW]), 32'(440));
            if (k == 24) chk("jump air@24", 32'(airborne[0]), 32'(1));
            if (k == 48) chk("jump y0@48", 32'(ypos_player[0 +: PW]), 32'(536));
            if (k == 48) chk("jump air@48", 32'(airborne[0]), 32'(0));
        end
        do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b01);
        chk("rejump y0", 32'(ypos_player[0 +: PW]), 32'(532));

        // Restart on a tick while falling at y0=480
        do_tick(1'b1, 1'b1, '0, '0, '0);
        do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b01);
        for (int k = 2; k <= 34; k++) do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        chk("fall y0", 32'(ypos_player[0 +: PW]), 32'(480));
        do_tick(1'b1, 1'b1, 2'b11, 2'b00, 2'b11);
        chk("restart y0", 32'(ypos_player[0 +: PW]), 32'(536));
        chk("restart air", 32'(airborne), 32'(0));
        chk("restart fd", 32'(frame_done), 32'(0));
        do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
        chk("post_restart y0", 32'(ypos_player[0 +: PW]), 32'(536));
        do_tick(1'b1, 1'b0, 2'b00, 2'b00, 2'b01);
        chk("post_restart jump", 32'(ypos_player[0 +: PW]), 32'(532));

        // Disabled ticks freeze everything
        for (int k = 0; k < 5; k++) do_tick(1'b0, 1'b0, 2'b11, 2'b11, 2'b11);
        chk("frozen y0", 32'(ypos_player[0 +: PW]), 32'(532));

        // Asynchronous reset mid-frame
        @(posedge clk_40);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("async_rst");
        @(negedge clk_40);
        rst = 1'b0;
        v_tick = 1'b0;
        @(posedge clk_40);

        // Randomized frames against the model
        for (int k = 0; k < 400; k++) begin
            do_tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0),
                    NP'($urandom), NP'($urandom),
                    NP'(($urandom_range(0, 3) == 0) ? $urandom : 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/player_motion_ctl.md
# player_motion_ctl

Parametrised N-player motion controller for the game datapath, running in the `clk_40` domain. It replaces the per-player single-channel control with one block that advances every player's sprite position once per video frame. Each channel takes per-player left/right/jump requests, saturates horizontal motion at the screen edges and runs a jump state machine. Outputs are packed position buses consumed by the state control and drawing stages, alongside the frame-tick-driven rectangle control.

## Interface
Parameters:
- `NUM_PLAYERS`, 2: number of independent player channels (1..8).
- `PW`, 12: position width in bits.
- `X_MIN`, 0: leftmost legal x.
- `X_MAX`, 768: rightmost legal x (screen width 800 − sprite width 32).
- `X_SPACING`, 200: reset x offset between consecutive players.
- `Y_FLOOR`, 536: ground y.
- `STEP`, 4: horizontal pixels per frame.
- `JUMP_STEP`, 4: vertical pixels per frame.
- `JUMP_HEIGHT`, 96: apex height above `Y_FLOOR`. Must be a multiple of `JUMP_STEP`.

Ports:
- `clk_40`  in  1  pixel clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `v_tick`  in  1  vsync level from VGA timing; the block detects its rising edge internally.
- `enable`  in  1  high while the game state is PLAYING; low freezes all motion.
- `restart`  in  1  synchronous one-cycle request to return all players to their reset positions.
- `m_left`  in  `NUM_PLAYERS`  per-player move-left request (bit i = player i).
- `m_right`  in  `NUM_PLAYERS`  per-player move-right request.
- `jump`  in  `NUM_PLAYERS`  per-player jump request.
- `xpos_player`  out  `NUM_PLAYERS*PW`  packed x positions; player i occupies `[i*PW +: PW]`.
- `ypos_player`  out  `NUM_PLAYERS*PW`  packed y positions, same packing.
- `airborne`  out  `NUM_PLAYERS`  high while player i is not in GROUND.
- `frame_done`  out  1  one-cycle pulse marking a position update.

## Operation
- Reset values:
  - x[i] = `X_MIN` + i·`X_SPACING`, y[i] = `Y_FLOOR`.
  - `airborne` = 0, `frame_done` = 0, all FSMs in GROUND.
  - Internal `v_tick` delay register = 1, so a high `v_tick` at reset release produces no tick.
- Tick condition: `v_tick`=1 and delayed `v_tick`=0. Requests are sampled on that same edge only; requests between ticks are ignored.
- Priority per edge: `restart` > tick with `enable`=1 > hold.
  - `restart` restores all reset values and suppresses `frame_done`.
  - A tick with `enable`=0 changes nothing and does not pulse `frame_done`.
- Horizontal, per channel, on an enabled tick:
  - left only: x = max(x−`STEP`, `X_MIN`), computed as "if x < `X_MIN`+`STEP` then `X_MIN`", which avoids unsigned underflow.
  - right only: x = min(x+`STEP`, `X_MAX`), computed in `PW`+1 bits.
  - both or neither: hold.
- Jump FSM per channel (GROUND, RISE, FALL), evaluated on an enabled tick in parallel with horizontal motion:
  - GROUND: `jump`=1 → y −= `JUMP_STEP`, go to RISE. Otherwise stay.
  - RISE: if y−`JUMP_STEP` ≤ `Y_FLOOR`−`JUMP_HEIGHT` → y = apex, go to FALL. Else y −= `JUMP_STEP`. `jump` is ignored.
  - FALL: if y+`JUMP_STEP` ≥ `Y_FLOOR` → y = `Y_FLOOR`, go to GROUND. Else y += `JUMP_STEP`. `jump` is ignored.
  - Holding `jump` through landing starts a new jump on the next tick after landing, not on the landing tick.
- Channels are fully independent. Any request mix across players is legal.
- `restart` mid-jump returns the FSM to GROUND immediately.
- Asynchronous `rst` mid-frame applies reset values at once.

## Timing
- All outputs are registered.
- Updated positions, `airborne` and `frame_done` are visible one `clk_40` cycle after the edge where the tick condition was true.
- `frame_done` is high for exactly one cycle per enabled tick.
- Latency from `v_tick` rising to new output: the `v_tick` setup edge plus one cycle. `v_tick` is synchronous to `clk_40`, so no synchroniser is needed.
- A full jump with defaults lasts 48 ticks: the apex y=440 is reached on tick 24, and y returns to 536 with `airborne`=0 after tick 48.
- Outputs are stable between ticks and safe for the drawing stage to sample at any time.

## Test plan
- Reset with defaults and `v_tick` held high → x = {0, 200}, y = {536, 536}, `airborne` = 0, no `frame_done` until `v_tick` falls and rises again.
- Player 0 `m_right` held for 200 ticks → x0 steps 4 per tick and saturates at 768 on tick 192. Player 1 with `m_left` saturates at 0 after 50 ticks.
- Both `m_left` and `m_right` high on player 1 for 10 ticks → x1 stays at 200. `frame_done` still pulses 10 times.
- Player 0 `jump` for one tick → y0 = 532, then reaches 440 on tick 24 (`airborne`=1). Jump presses during ticks 2–47 have no effect. y0 = 536 and `airborne` = 0 after tick 48.
- `enable` = 0 for 5 ticks with all requests high → positions and FSM unchanged, no `frame_done`.
- `restart` asserted on the same edge as a tick while player 0 is at y0 = 480 in FALL → all positions return to reset values, FSM returns to GROUND, no `frame_done`.
